core_lsu_s: RTL and testbench

- Load/store unit sitting after the execute stage. It receives the 7-bit L1D request bus that decode produces, plus the execute-stage address and store data.
- It runs a req/ack handshake with the level 1 data cache, stalling the pipeline while the access is outstanding.
- For loads, it lane-extracts and sign/zero-extends the returned data per the writeback extension op, then drives the register-file write port (data, rd, we).

---
 rtl/core_pkg.sv | 48 ++++
 rtl/core_lsu_ext.sv | 25 ++
 rtl/core_lsu_s.sv | 136 +++++++++++++
 tb/tb_core_lsu_s.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared codes, request-bus layout and helpers for the core LSU
package core_pkg;

  localparam int REQ_VLD = 6;
  localparam int REQ_CACHE = 4;
  localparam int REQ_WRITE = 3;

  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  localparam logic [2:0] WB_SX_BP  = 3'd0;
  localparam logic [2:0] WB_SX_B   = 3'd1;
  localparam logic [2:0] WB_SX_UB  = 3'd2;
  localparam logic [2:0] WB_SX_H   = 3'd3;
  localparam logic [2:0] WB_SX_UH  = 3'd4;
  localparam logic [2:0] WB_SX_IMM = 3'd5;
  localparam logic [2:0] WB_SX_PC  = 3'd6;

  typedef enum logic {LSU_IDLE, LSU_WAIT} lsu_state_e;

  // Legal size code with a naturally aligned offset.
  function automatic logic lsu_req_ok(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    lsu_req_ok = 1'b1;
      SZ_H:    lsu_req_ok = ~off[0];
      SZ_W:    lsu_req_ok = (off == 2'b00);
      default: lsu_req_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    lsu_be = 4'b0001 << off;
      SZ_H:    lsu_be = off[1] ? 4'b1100 : 4'b0011;
      default: lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    lsu_wdata = {4{wd[7:0]}};
      SZ_H:    lsu_wdata = {2{wd[15:0]}};
      default: lsu_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_ext.sv
// rtl/core_lsu_ext.sv - load lane extraction and sign/zero extension
module core_lsu_ext
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  sx_op,
  output logic [31:0] data
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata >> {off, 3'b000});
    case (sx_op)
      WB_SX_B:  data = {{24{lane[7]}}, lane[7:0]};
      WB_SX_UB: data = {24'd0, lane[7:0]};
      WB_SX_H:  data = {{16{lane[15]}}, lane};
      WB_SX_UH: data = {16'd0, lane};
      // BP, and IMM/PC which make no sense on a load, pass the word through
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/core_lsu_s.sv
// rtl/core_lsu_s.sv - load/store unit: L1D req/ack handshake, pipeline stall, load writeback
module core_lsu_s
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_kill_in,
  input  logic [6:0]  lsu_req_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_wdata_in,
  input  logic [2:0]  lsu_wb_sx_op_in,
  input  logic [4:0]  lsu_rd_in,
  output logic        l1d_req_val_out,
  output logic [31:0] l1d_addr_out,
  output logic [31:0] l1d_wdata_out,
  output logic [3:0]  l1d_be_out,
  output logic        l1d_we_out,
  output logic        l1d_cacheable_out,
  input  logic        l1d_ack_in,
  input  logic [31:0] l1d_rdata_in,
  output logic        lsu_stall_out,
  output logic        lsu_wb_we_out,
  output logic [4:0]  lsu_wb_rd_out,
  output logic [31:0] lsu_wb_data_out,
  output logic        lsu_misalign_out,
  output logic        lsu_err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [2:0]    sx_q;
  logic [4:0]    rd_q;
  logic          kill_q;
  logic [31:0]   ext_data;

  logic [2:0] sz;
  logic       req_vld, req_ok, accept, bad_req, timeout;
  logic       unused_rsvd;

  assign sz          = lsu_req_in[2:0];
  assign req_vld     = lsu_req_in[REQ_VLD];
  assign req_ok      = lsu_req_ok(sz, lsu_addr_in[1:0]);
  assign accept      = req_vld & req_ok & ~lsu_kill_in;
  assign bad_req     = req_vld & ~req_ok & ~lsu_kill_in;
  assign timeout     = (cnt == CW'(TIMEOUT - 1)) & ~l1d_ack_in;
  assign unused_rsvd = lsu_req_in[5];

  assign l1d_addr_out = {addr_q[31:2], 2'b00};

  core_lsu_ext u_ext (
    .rdata (l1d_rdata_in),
    .off   (addr_q[1:0]),
    .sx_op (sx_q),
    .data  (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (accept) state_nxt = LSU_WAIT;
      LSU_WAIT: if (l1d_ack_in || timeout) state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    l1d_req_val_out = (state == LSU_WAIT);
    lsu_stall_out   = ~rst & (((state == LSU_IDLE) & accept) | (state == LSU_WAIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt               <= '0;
      addr_q            <= '0;
      sx_q              <= '0;
      rd_q              <= '0;
      kill_q            <= 1'b0;
      l1d_wdata_out     <= '0;
      l1d_be_out        <= '0;
      l1d_we_out        <= 1'b0;
      l1d_cacheable_out <= 1'b0;
      lsu_wb_we_out     <= 1'b0;
      lsu_wb_rd_out     <= '0;
      lsu_wb_data_out   <= '0;
      lsu_misalign_out  <= 1'b0;
      lsu_err_out       <= 1'b0;
    end else begin
      lsu_wb_we_out    <= 1'b0;
      lsu_misalign_out <= 1'b0;
      lsu_err_out      <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            cnt               <= '0;
            kill_q            <= 1'b0;
            addr_q            <= lsu_addr_in;
            sx_q              <= lsu_wb_sx_op_in;
            rd_q              <= lsu_rd_in;
            l1d_wdata_out     <= lsu_wdata(sz, lsu_wdata_in);
            l1d_be_out        <= lsu_be(sz, lsu_addr_in[1:0]);
            l1d_we_out        <= lsu_req_in[REQ_WRITE];
            l1d_cacheable_out <= lsu_req_in[REQ_CACHE];
          end else if (bad_req) begin
            lsu_misalign_out <= 1'b1;
          end
        end
        LSU_WAIT: begin
          cnt <= cnt + CW'(1);
          if (lsu_kill_in) kill_q <= 1'b1;
          // An ack in the timeout cycle still completes normally
          if (l1d_ack_in) begin
            if (!l1d_we_out && !kill_q && !lsu_kill_in) begin
              lsu_wb_we_out   <= 1'b1;
              lsu_wb_rd_out   <= rd_q;
              lsu_wb_data_out <= ext_data;
            end
          end else if (timeout) begin
            lsu_err_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu_s.sv
// tb/tb_core_lsu_s.sv - scoreboard bench for core_lsu_s with directed vectors
module tb_core_lsu_s;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_kill_in = 1'b0;
  logic [6:0]  lsu_req_in = '0;
  logic [31:0] lsu_addr_in = '0;
  logic [31:0] lsu_wdata_in = '0;
  logic [2:0]  lsu_wb_sx_op_in = '0;
  logic [4:0]  lsu_rd_in = '0;
  logic        l1d_ack_in = 1'b0;
  logic [31:0] l1d_rdata_in = '0;
  logic        l1d_req_val_out, l1d_we_out, l1d_cacheable_out;
  logic [31:0] l1d_addr_out, l1d_wdata_out;
  logic [3:0]  l1d_be_out;
  logic        lsu_stall_out, lsu_wb_we_out, lsu_misalign_out, lsu_err_out;
  logic [4:0]  lsu_wb_rd_out;
  logic [31:0] lsu_wb_data_out;

  core_lsu_s #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .lsu_kill_in(lsu_kill_in), .lsu_req_in(lsu_req_in),
    .lsu_addr_in(lsu_addr_in), .lsu_wdata_in(lsu_wdata_in), .lsu_wb_sx_op_in(lsu_wb_sx_op_in),
    .lsu_rd_in(lsu_rd_in), .l1d_req_val_out(l1d_req_val_out), .l1d_addr_out(l1d_addr_out),
    .l1d_wdata_out(l1d_wdata_out), .l1d_be_out(l1d_be_out), .l1d_we_out(l1d_we_out),
    .l1d_cacheable_out(l1d_cacheable_out), .l1d_ack_in(l1d_ack_in), .l1d_rdata_in(l1d_rdata_in),
    .lsu_stall_out(lsu_stall_out), .lsu_wb_we_out(lsu_wb_we_out), .lsu_wb_rd_out(lsu_wb_rd_out),
    .lsu_wb_data_out(lsu_wb_data_out), .lsu_misalign_out(lsu_misalign_out), .lsu_err_out(lsu_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; logic cach;} req_t;
  typedef struct {logic [31:0] data; logic [4:0] rd;} wb_t;
  typedef struct {int stall; int reqc;} cnt_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  cnt_t exp_cnt[$];
  int   exp_mis[$];
  int   exp_err[$];
  logic txn_done = 1'b0;
  logic all_done = 1'b0;
  int   total = 0;
  int   bad = 0;

  localparam logic [6:0] RQ_LW  = 7'h54;
  localparam logic [6:0] RQ_LH  = 7'h52;
  localparam logic [6:0] RQ_LB  = 7'h41;
  localparam logic [6:0] RQ_SH  = 7'h5A;
  localparam logic [6:0] RQ_SB  = 7'h59;
  localparam logic [6:0] RQ_BAD = 7'h53;

  // Monitor: pops the scoreboard whenever the DUT presents something
  initial begin
    int   stall_acc;
    int   reqc_acc;
    logic prev_val;
    req_t r;
    wb_t  w;
    cnt_t c;
    stall_acc = 0; reqc_acc = 0; prev_val = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        total++;
        if ({l1d_req_val_out, l1d_addr_out, l1d_wdata_out, l1d_be_out, l1d_we_out, l1d_cacheable_out,
             lsu_stall_out, lsu_wb_we_out, lsu_wb_rd_out, lsu_wb_data_out, lsu_misalign_out,
             lsu_err_out} != '0) begin
          bad++;
          $display("FAIL rst_outputs: req_val=%b addr=%h be=%h stall=%b wb_we=%b wb_data=%h, all required 0",
                   l1d_req_val_out, l1d_addr_out, l1d_be_out, lsu_stall_out, lsu_wb_we_out, lsu_wb_data_out);
        end
        stall_acc = 0; reqc_acc = 0; prev_val = 1'b0;
      end else begin
        if (txn_done) begin
          total++;
          if (exp_cnt.size() == 0) begin
            bad++; $display("FAIL txn_counts: no expectation queued");
          end else begin
            c = exp_cnt.pop_front();
            if (stall_acc != c.stall || reqc_acc != c.reqc) begin
              bad++;
              $display("FAIL txn_counts: stall=%0d req_val=%0d cycles, required stall=%0d req_val=%0d",
                       stall_acc, reqc_acc, c.stall, c.reqc);
            end
          end
          stall_acc = 0; reqc_acc = 0;
        end
        if (lsu_stall_out) stall_acc++;
        if (l1d_req_val_out) reqc_acc++;
        if (l1d_req_val_out && !prev_val) begin
          total++;
          if (exp_req.size() == 0) begin
            bad++; $display("FAIL l1d_req: unexpected request addr=%h", l1d_addr_out);
          end else begin
            r = exp_req.pop_front();
            if (l1d_addr_out != r.addr || l1d_be_out != r.be || l1d_we_out != r.we ||
                l1d_cacheable_out != r.cach || (r.we && l1d_wdata_out != r.wdata)) begin
              bad++;
              $display("FAIL l1d_req: addr=%h be=%b we=%b c=%b wdata=%h, required addr=%h be=%b we=%b c=%b wdata=%h",
                       l1d_addr_out, l1d_be_out, l1d_we_out, l1d_cacheable_out, l1d_wdata_out,
                       r.addr, r.be, r.we, r.cach, r.wdata);
            end
          end
        end
        prev_val = l1d_req_val_out;
        if (lsu_wb_we_out) begin
          total++;
          if (exp_wb.size() == 0) begin
            bad++; $display("FAIL wb: unexpected writeback data=%h rd=%0d", lsu_wb_data_out, lsu_wb_rd_out);
          end else begin
            w = exp_wb.pop_front();
            if (lsu_wb_data_out != w.data || lsu_wb_rd_out != w.rd) begin
              bad++;
              $display("FAIL wb: data=%h rd=%0d, required data=%h rd=%0d",
                       lsu_wb_data_out, lsu_wb_rd_out, w.data, w.rd);
            end
          end
        end
        if (lsu_misalign_out) begin
          total++;
          if (exp_mis.size() == 0) begin
            bad++; $display("FAIL misalign: unexpected pulse, required none");
          end else void'(exp_mis.pop_front());
        end
        if (lsu_err_out) begin
          total++;
          if (exp_err.size() == 0) begin
            bad++; $display("FAIL err: unexpected pulse, required none");
          end else void'(exp_err.pop_front());
        end
        if (all_done) begin
          total++;
          if (exp_req.size() + exp_wb.size() + exp_cnt.size() + exp_mis.size() + exp_err.size() != 0) begin
            bad++;
            $display("FAIL leftover: req=%0d wb=%0d cnt=%0d mis=%0d err=%0d pending, required 0",
                     exp_req.size(), exp_wb.size(), exp_cnt.size(), exp_mis.size(), exp_err.size());
          end
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  task automatic idle_inputs();
    lsu_req_in = '0; lsu_kill_in = 1'b0; l1d_ack_in = 1'b0; l1d_rdata_in = '0;
  endtask

  task automatic txn(input logic [6:0] req, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] sx, input logic [4:0] rd, input int ack_at,
                     input logic [31:0] rdata, input int kill_at, input int ncyc,
                     input int es, input int er);
    cnt_t c;
    for (int j = 0; j < ncyc; j++) begin
      lsu_req_in      = (j == 0) ? req : 7'd0;
      lsu_addr_in     = addr;
      lsu_wdata_in    = wdata;
      lsu_wb_sx_op_in = sx;
      lsu_rd_in       = rd;
      l1d_ack_in      = (j == ack_at);
      l1d_rdata_in    = (j == ack_at) ? rdata : 32'd0;
      lsu_kill_in     = (j == kill_at);
      @(posedge clk); #1;
    end
    idle_inputs();
    c.stall = es; c.reqc = er;
    exp_cnt.push_back(c);
    txn_done = 1'b1;
    @(posedge clk); #1;
    txn_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    exp_req.push_back('{32'h100, 4'b1111, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'hDEADBEEF, 5'd5});
    txn(RQ_LW, 32'h100, 32'h11223344, WB_SX_BP, 5'd5, 3, 32'hDEADBEEF, -1, 6, 4, 3);

    exp_req.push_back('{32'h200, 4'b1000, 32'h0, 1'b0, 1'b0});
    exp_wb.push_back('{32'hFFFFFF80, 5'd6});
    txn(RQ_LB, 32'h203, 32'hA5, WB_SX_B, 5'd6, 1, 32'h80FF1234, -1, 4, 2, 1);

    exp_req.push_back('{32'h200, 4'b1000, 32'h0, 1'b0, 1'b0});
    exp_wb.push_back('{32'h00000080, 5'd6});
    txn(RQ_LB, 32'h203, 32'hA5, WB_SX_UB, 5'd6, 1, 32'h80FF1234, -1, 4, 2, 1);

    exp_req.push_back('{32'h300, 4'b1100, 32'hABCDABCD, 1'b1, 1'b1});
    txn(RQ_SH, 32'h302, 32'h0000ABCD, WB_SX_BP, 5'd3, 2, 32'h0, -1, 5, 3, 2);

    exp_req.push_back('{32'h400, 4'b1100, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'hFFFF8001, 5'd7});
    txn(RQ_LH, 32'h402, 32'h0, WB_SX_H, 5'd7, 1, 32'h80017FFF, -1, 4, 2, 1);

    exp_req.push_back('{32'h400, 4'b0011, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'h0000F00F, 5'd8});
    txn(RQ_LH, 32'h400, 32'h0, WB_SX_UH, 5'd8, 1, 32'h8001F00F, -1, 4, 2, 1);

    exp_req.push_back('{32'h404, 4'b1111, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'hCAFEF00D, 5'd10});
    txn(RQ_LW, 32'h404, 32'h0, WB_SX_IMM, 5'd10, 1, 32'hCAFEF00D, -1, 4, 2, 1);

    exp_req.push_back('{32'h500, 4'b0010, 32'h3C3C3C3C, 1'b1, 1'b1});
    txn(RQ_SB, 32'h501, 32'h1234563C, WB_SX_BP, 5'd1, 1, 32'h0, -1, 4, 2, 1);

    exp_mis.push_back(1);
    txn(RQ_LW, 32'h101, 32'h0, WB_SX_BP, 5'd2, -1, 32'h0, -1, 3, 0, 0);
    exp_mis.push_back(1);
    txn(RQ_BAD, 32'h200, 32'h0, WB_SX_BP, 5'd2, -1, 32'h0, -1, 3, 0, 0);
    exp_mis.push_back(1);
    txn(RQ_SH, 32'h301, 32'h0, WB_SX_BP, 5'd2, -1, 32'h0, -1, 3, 0, 0);

    exp_req.push_back('{32'h600, 4'b1111, 32'h0, 1'b0, 1'b1});
    exp_err.push_back(1);
    txn(RQ_LW, 32'h600, 32'h0, WB_SX_BP, 5'd4, -1, 32'h0, -1, 8, 5, 4);

    exp_req.push_back('{32'h104, 4'b1111, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'h12345678, 5'd9});
    txn(RQ_LW, 32'h104, 32'h0, WB_SX_BP, 5'd9, 1, 32'h12345678, -1, 4, 2, 1);

    exp_req.push_back('{32'h108, 4'b1111, 32'h0, 1'b0, 1'b1});
    txn(RQ_LW, 32'h108, 32'h0, WB_SX_BP, 5'd11, 3, 32'h55555555, 2, 6, 4, 3);

    txn(RQ_LW, 32'h10C, 32'h0, WB_SX_BP, 5'd12, 1, 32'h77777777, 0, 3, 0, 0);

    // Asynchronous reset in the middle of an outstanding load
    exp_req.push_back('{32'h800, 4'b1111, 32'h0, 1'b0, 1'b1});
    lsu_req_in = RQ_LW; lsu_addr_in = 32'h800; lsu_rd_in = 5'd13;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    exp_req.push_back('{32'h700, 4'b1111, 32'h0, 1'b0, 1'b1});
    exp_wb.push_back('{32'hA5A50001, 5'd12});
    txn(RQ_LW, 32'h700, 32'h0, WB_SX_BP, 5'd12, 1, 32'hA5A50001, -1, 4, 2, 1);

    all_done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL finish_timeout: monitor did not close the run");
    $fatal(1);
  end

endmodule
